// File: rtl/pacman_pkg.sv
// Shared types, key codes and key/direction conversion for the pacman movement controller.
package pacman_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READY = 3'd1,
        PLAY  = 3'd2,
        DYING = 3'd3,
        CLEAR = 3'd4,
        OVER  = 3'd5,
        PAUSE = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        NONE  = 3'd0,
        UP    = 3'd1,
        DOWN  = 3'd2,
        LEFT  = 3'd3,
        RIGHT = 3'd4
    } dir_t;

    localparam logic [7:0] KEY_NONE  = 8'h00;
    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_D     = 8'h07;
    localparam logic [7:0] KEY_S     = 8'h16;
    localparam logic [7:0] KEY_W     = 8'h1A;
    localparam logic [7:0] KEY_SPACE = 8'h2C;
    localparam logic [7:0] KEY_P     = 8'h13;

    function automatic logic [7:0] dir_to_key(dir_t d);
        case (d)
            UP:      return KEY_W;
            DOWN:    return KEY_S;
            LEFT:    return KEY_A;
            RIGHT:   return KEY_D;
            default: return KEY_NONE;
        endcase
    endfunction

    function automatic dir_t key_to_dir(logic [7:0] k);
        case (k)
            KEY_W:   return UP;
            KEY_S:   return DOWN;
            KEY_A:   return LEFT;
            KEY_D:   return RIGHT;
            default: return NONE;
        endcase
    endfunction

endpackage

// File: rtl/pacman_move_ctrl_if.sv
// Signal bundle between keyboard/maze/mover side (master) and the movement controller (slave).
interface pacman_move_ctrl_if;
    import pacman_pkg::*;

    logic [7:0] keycode;
    logic       UpWall;
    logic       DownWall;
    logic       LeftWall;
    logic       RightWall;
    logic       ghost_hit;
    logic       dots_done;
    logic [7:0] mover_key;
    logic       mover_reset;
    logic       mover_hold;
    logic [1:0] lives;
    state_t     game_state;

    modport master (
        output keycode, UpWall, DownWall, LeftWall, RightWall, ghost_hit, dots_done,
        input  mover_key, mover_reset, mover_hold, lives, game_state
    );

    modport slave (
        input  keycode, UpWall, DownWall, LeftWall, RightWall, ghost_hit, dots_done,
        output mover_key, mover_reset, mover_hold, lives, game_state
    );

endinterface

// File: rtl/pacman_turn_buf.sv
// Pre-turn buffer: remembers the last direction key and issues it once its wall opens, or drops it
// after TURN_HOLD blocked frames. Also tracks the mover's current direction.
module pacman_turn_buf
    import pacman_pkg::*;
#(
    parameter int TURN_HOLD = 16
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic       en,
    input  logic       clr,
    input  logic [7:0] key,
    input  logic       UpWall,
    input  logic       DownWall,
    input  logic       LeftWall,
    input  logic       RightWall,
    output logic       issue,
    output dir_t       issue_dir
);

    localparam int HOLD_W = $clog2(TURN_HOLD + 1);

    dir_t              pend_dir;
    dir_t              cur_dir;
    dir_t              key_dir;
    dir_t              eff_dir;
    logic [HOLD_W-1:0] hold_cnt;
    logic              eff_wall;
    logic              cur_wall;

    function automatic logic wall_for(dir_t d, logic [3:0] w);
        case (d)
            UP:      return w[3];
            DOWN:    return w[2];
            LEFT:    return w[1];
            RIGHT:   return w[0];
            default: return 1'b0;
        endcase
    endfunction

    // A fresh key takes effect in the frame it arrives; otherwise the pending entry is evaluated.
    always_comb begin
        key_dir   = key_to_dir(key);
        eff_dir   = (key_dir != NONE) ? key_dir : pend_dir;
        eff_wall  = wall_for(eff_dir, {UpWall, DownWall, LeftWall, RightWall});
        cur_wall  = wall_for(cur_dir, {UpWall, DownWall, LeftWall, RightWall});
        issue     = en && (eff_dir != NONE) && (eff_dir != cur_dir) && !eff_wall;
        issue_dir = eff_dir;
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset || clr) begin
            pend_dir <= NONE;
            cur_dir  <= NONE;
            hold_cnt <= '0;
        end else if (en) begin
            if (issue) begin
                cur_dir  <= eff_dir;
                pend_dir <= NONE;
                hold_cnt <= '0;
            end else begin
                if (cur_wall)
                    cur_dir <= NONE;
                if (eff_dir == NONE) begin
                    pend_dir <= NONE;
                end else if (eff_dir == cur_dir) begin
                    pend_dir <= NONE;
                    hold_cnt <= '0;
                end else if (key_dir != NONE) begin
                    pend_dir <= key_dir;
                    hold_cnt <= HOLD_W'(TURN_HOLD);
                end else if (hold_cnt == HOLD_W'(1) || hold_cnt == '0) begin
                    pend_dir <= NONE;
                    hold_cnt <= '0;
                end else begin
                    hold_cnt <= hold_cnt - HOLD_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/pacman_move_ctrl.sv
// Game flow sequencer for the player mover (IDLE/READY/PLAY/DYING/CLEAR/OVER).
// Define PACMAN_CTRL_PAUSE_EN to add a P-key toggled PAUSE state.
module pacman_move_ctrl
    import pacman_pkg::*;
#(
    parameter int READY_FRAMES = 120,
    parameter int DEATH_FRAMES = 90,
    parameter int START_LIVES  = 3,
    parameter int TURN_HOLD    = 16
) (
    input  logic              frame_clk,
    input  logic              Reset,
    pacman_move_ctrl_if.slave bus
);

    localparam int CNT_MAX = (READY_FRAMES > DEATH_FRAMES) ? READY_FRAMES : DEATH_FRAMES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [1:0]       lives, lives_nxt;
    logic [7:0]       prev_key;
    logic [7:0]       mover_key;
    logic             mover_reset;
    logic             mover_hold;
    logic             space_edge;
    logic             issue;
    dir_t             issue_dir;

    assign space_edge = (bus.keycode == KEY_SPACE) && (bus.keycode != prev_key);

`ifdef PACMAN_CTRL_PAUSE_EN
    logic p_edge;
    assign p_edge = (bus.keycode == KEY_P) && (bus.keycode != prev_key);
`endif

    pacman_turn_buf #(
        .TURN_HOLD (TURN_HOLD)
    ) u_turn_buf (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .en        (state == PLAY),
        .clr       ((state != PLAY) && (state != PAUSE)),
        .key       (bus.keycode),
        .UpWall    (bus.UpWall),
        .DownWall  (bus.DownWall),
        .LeftWall  (bus.LeftWall),
        .RightWall (bus.RightWall),
        .issue     (issue),
        .issue_dir (issue_dir)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        lives_nxt = lives;
        case (state)
            IDLE: if (space_edge) begin
                state_nxt = READY;
                cnt_nxt   = '0;
                lives_nxt = 2'(START_LIVES);
            end
            READY: if (cnt == CNT_W'(READY_FRAMES - 1)) begin
                state_nxt = PLAY;
                cnt_nxt   = '0;
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
            // A collision outranks a level clear arriving in the same frame.
            PLAY: if (bus.ghost_hit) begin
                state_nxt = DYING;
                cnt_nxt   = '0;
                lives_nxt = (lives != 2'd0) ? lives - 2'd1 : 2'd0;
            end else if (bus.dots_done) begin
                state_nxt = CLEAR;
`ifdef PACMAN_CTRL_PAUSE_EN
            end else if (p_edge) begin
                state_nxt = PAUSE;
`endif
            end
            DYING: if (cnt == CNT_W'(DEATH_FRAMES - 1)) begin
                state_nxt = (lives == 2'd0) ? OVER : READY;
                cnt_nxt   = '0;
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
            CLEAR: if (space_edge) begin
                state_nxt = READY;
                cnt_nxt   = '0;
            end
            OVER: if (space_edge)
                state_nxt = IDLE;
`ifdef PACMAN_CTRL_PAUSE_EN
            PAUSE: if (p_edge)
                state_nxt = PLAY;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs follow the next state so they line up with game_state.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state       <= IDLE;
            cnt         <= '0;
            lives       <= 2'(START_LIVES);
            prev_key    <= 8'h00;
            mover_key   <= 8'h00;
            mover_reset <= 1'b1;
            mover_hold  <= 1'b1;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            lives       <= lives_nxt;
            prev_key    <= bus.keycode;
            mover_key   <= (issue && state_nxt == PLAY) ? dir_to_key(issue_dir) : 8'h00;
            mover_reset <= (state_nxt == IDLE) || (state_nxt == READY);
            mover_hold  <= (state_nxt != PLAY);
        end
    end

    assign bus.mover_key   = mover_key;
    assign bus.mover_reset = mover_reset;
    assign bus.mover_hold  = mover_hold;
    assign bus.lives       = lives;
    assign bus.game_state  = state;

endmodule

// File: tb/tb_pacman_move_ctrl.sv
// Directed bench for pacman_move_ctrl: game flow, turn buffering, lives and the optional pause.
module tb_pacman_move_ctrl;
    import pacman_pkg::*;

    logic frame_clk;
    logic Reset;
    int   checks;
    int   failures;

    pacman_move_ctrl_if bus();

    pacman_move_ctrl #(
        .READY_FRAMES (120),
        .DEATH_FRAMES (90),
        .START_LIVES  (3),
        .TURN_HOLD    (16)
    ) dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .bus       (bus)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge frame_clk);
        #1;
    endtask

    // Called right after the READY entry frame; READY must last exactly 120 frames.
    task automatic ready_to_play(input string tag);
        repeat (119) tick();
        chk({tag, "_ready_last"}, bus.game_state, READY);
        chk({tag, "_ready_rst"}, bus.mover_reset, 1'b1);
        tick();
        chk({tag, "_play"}, bus.game_state, PLAY);
        chk({tag, "_play_rst"}, bus.mover_reset, 1'b0);
        chk({tag, "_play_hold"}, bus.mover_hold, 1'b0);
    endtask

    task automatic die(input string tag, input logic [1:0] exp_lives, input state_t after);
        bus.ghost_hit = 1'b1;
        tick();
        bus.ghost_hit = 1'b0;
        bus.dots_done = 1'b0;
        chk({tag, "_dying"}, bus.game_state, DYING);
        chk({tag, "_lives"}, bus.lives, exp_lives);
        repeat (89) tick();
        chk({tag, "_dying_last"}, bus.game_state, DYING);
        tick();
        chk({tag, "_after"}, bus.game_state, after);
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        Reset         = 1'b1;
        bus.keycode   = KEY_NONE;
        bus.UpWall    = 1'b0;
        bus.DownWall  = 1'b0;
        bus.LeftWall  = 1'b0;
        bus.RightWall = 1'b0;
        bus.ghost_hit = 1'b0;
        bus.dots_done = 1'b0;
        repeat (2) tick();
        Reset = 1'b0;

        chk("rst_state", bus.game_state, IDLE);
        chk("rst_key", bus.mover_key, KEY_NONE);
        chk("rst_mreset", bus.mover_reset, 1'b1);
        chk("rst_hold", bus.mover_hold, 1'b1);
        chk("rst_lives", bus.lives, 2'd3);
        tick();
        chk("idle_stay", bus.game_state, IDLE);

        // 1: start a game
        bus.keycode = KEY_SPACE;
        tick();
        bus.keycode = KEY_NONE;
        chk("t1_ready", bus.game_state, READY);
        chk("t1_lives", bus.lives, 2'd3);
        ready_to_play("t1");
        chk("t1_play_lives", bus.lives, 2'd3);

        // 2: left turn held behind a wall, issued the frame after the wall opens
        bus.LeftWall = 1'b1;
        bus.keycode  = KEY_A;
        tick();
        bus.keycode = KEY_NONE;
        chk("t2_blocked0", bus.mover_key, KEY_NONE);
        repeat (4) tick();
        chk("t2_blocked4", bus.mover_key, KEY_NONE);
        bus.LeftWall = 1'b0;
        tick();
        chk("t2_issue", bus.mover_key, KEY_A);
        tick();
        chk("t2_pulse_end", bus.mover_key, KEY_NONE);

        // 3: up turn blocked for the whole hold window is dropped
        bus.UpWall  = 1'b1;
        bus.keycode = KEY_W;
        tick();
        bus.keycode = KEY_NONE;
        repeat (16) tick();
        chk("t3_blocked", bus.mover_key, KEY_NONE);
        bus.UpWall = 1'b0;
        tick();
        chk("t3_dropped", bus.mover_key, KEY_NONE);
        tick();
        chk("t3_dropped2", bus.mover_key, KEY_NONE);

        // 3b: last frame of the hold window still issues
        bus.RightWall = 1'b1;
        bus.keycode   = KEY_D;
        tick();
        bus.keycode = KEY_NONE;
        repeat (15) tick();
        chk("t3b_blocked", bus.mover_key, KEY_NONE);
        bus.RightWall = 1'b0;
        tick();
        chk("t3b_issue", bus.mover_key, KEY_D);
        tick();
        chk("t3b_pulse_end", bus.mover_key, KEY_NONE);

        // 4: lose all lives; last death has ghost_hit and dots_done together
        die("t4a", 2'd2, READY);
        ready_to_play("t4a");
        die("t4b", 2'd1, READY);
        ready_to_play("t4b");
        bus.dots_done = 1'b1;
        die("t4c", 2'd0, OVER);
        chk("t4_over_lives", bus.lives, 2'd0);
        chk("t4_over_hold", bus.mover_hold, 1'b1);
        bus.keycode = KEY_SPACE;
        tick();
        bus.keycode = KEY_NONE;
        chk("t4_idle", bus.game_state, IDLE);
        tick();

        // 5: new game, clear the level, hold space for 10 frames
        bus.keycode = KEY_SPACE;
        tick();
        bus.keycode = KEY_NONE;
        chk("t5_ready", bus.game_state, READY);
        chk("t5_lives_reload", bus.lives, 2'd3);
        ready_to_play("t5a");
        bus.dots_done = 1'b1;
        tick();
        bus.dots_done = 1'b0;
        chk("t5_clear", bus.game_state, CLEAR);
        chk("t5_clear_lives", bus.lives, 2'd3);
        chk("t5_clear_hold", bus.mover_hold, 1'b1);
        tick();
        chk("t5_clear_stay", bus.game_state, CLEAR);
        bus.keycode = KEY_SPACE;
        tick();
        chk("t5_reentry", bus.game_state, READY);
        repeat (9) tick();
        bus.keycode = KEY_NONE;
        repeat (110) tick();
        chk("t5_ready_last", bus.game_state, READY);
        tick();
        chk("t5_play", bus.game_state, PLAY);
        chk("t5_lives", bus.lives, 2'd3);

        // 6: P key with a pending left turn
        bus.LeftWall = 1'b1;
        bus.keycode  = KEY_A;
        tick();
        bus.keycode = KEY_P;
        tick();
        bus.keycode = KEY_NONE;
`ifdef PACMAN_CTRL_PAUSE_EN
        chk("t6_pause", bus.game_state, PAUSE);
        chk("t6_pause_hold", bus.mover_hold, 1'b1);
        bus.LeftWall  = 1'b0;
        bus.ghost_hit = 1'b1;
        tick();
        bus.ghost_hit = 1'b0;
        chk("t6_ghost_ignored", bus.game_state, PAUSE);
        chk("t6_pause_lives", bus.lives, 2'd3);
        chk("t6_pause_key", bus.mover_key, KEY_NONE);
        bus.keycode = KEY_P;
        tick();
        bus.keycode = KEY_NONE;
        chk("t6_resume", bus.game_state, PLAY);
        chk("t6_resume_key", bus.mover_key, KEY_NONE);
        tick();
        chk("t6_issue", bus.mover_key, KEY_A);
`else
        chk("t6_no_pause", bus.game_state, PLAY);
        chk("t6_no_pause_hold", bus.mover_hold, 1'b0);
        bus.LeftWall = 1'b0;
        tick();
        chk("t6_issue", bus.mover_key, KEY_A);
`endif

        // Asynchronous reset mid-frame
        #2 Reset = 1'b1;
        #1;
        chk("arst_state", bus.game_state, IDLE);
        chk("arst_key", bus.mover_key, KEY_NONE);
        chk("arst_mreset", bus.mover_reset, 1'b1);
        chk("arst_hold", bus.mover_hold, 1'b1);
        chk("arst_lives", bus.lives, 2'd3);
        tick();
        Reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
